// File: rtl/booth8_row_accumulator_pkg.sv
// rtl/booth8_row_accumulator_pkg.sv - shared widths, state enum and row alignment helper
package booth8_row_accumulator_pkg;

    localparam int X_W         = 13;
    localparam int Y_W         = 12;
    localparam int ROW_W       = 16;
    localparam int ACC_W       = 28;
    localparam int PROD_W      = 25;
    localparam int N_DIGITS    = 4;
    localparam int DIGIT_SHIFT = 3;
    localparam int YREG_W      = Y_W + 1;
    localparam int K_W         = $clog2(N_DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One's-complement row plus its +1 correction, aligned to digit position k.
    function automatic logic [ACC_W-1:0] row_term(
        input logic [ROW_W-1:0] row,
        input logic             neg,
        input logic [K_W-1:0]   k
    );
        logic [ACC_W-1:0] t;
        t = {{(ACC_W-ROW_W){row[ROW_W-1]}}, row} + {{(ACC_W-1){1'b0}}, neg};
        return t << (DIGIT_SHIFT * int'(k));
    endfunction

endpackage

// File: rtl/booth8_digit_shifter.sv
// rtl/booth8_digit_shifter.sv - multiplier register yielding overlapping radix-8 Booth digits
module booth8_digit_shifter
    import booth8_row_accumulator_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [Y_W-1:0] mplier,
    output logic [3:0]     digit
);

    logic [YREG_W-1:0] yreg;

    // Appended zero is the implicit y[-1]; arithmetic shift keeps the sign for the top digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            yreg <= '0;
        end else if (load) begin
            yreg <= {mplier, 1'b0};
        end else if (shift) begin
            yreg <= {{DIGIT_SHIFT{yreg[YREG_W-1]}}, yreg[YREG_W-1:DIGIT_SHIFT]};
        end
    end

    assign digit = yreg[3:0];

endmodule

// File: rtl/booth8_row_accumulator.sv
// rtl/booth8_row_accumulator.sv - sequential radix-8 Booth 13x12 signed multiplier around an external row generator
module booth8_row_accumulator
    import booth8_row_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [X_W-1:0]    mcand_i,
    input  logic [Y_W-1:0]    mplier_i,
    output logic [3:0]        digit_o,
    output logic [ROW_W-1:0]  row_src_o,
    input  logic [ROW_W-1:0]  row_i,
    output logic [PROD_W-1:0] prod_o,
    output logic              prod_valid_o,
    input  logic              prod_ready_i
);

    state_t            state;
    logic [K_W-1:0]    k;
    logic [ACC_W-1:0]  acc;
    logic [ROW_W-1:0]  row_src;
    logic [3:0]        digit;
    logic              accept;
    logic              run;
    logic              unused_acc_hi;

    assign accept = start_i && (state == IDLE);
    assign run    = (state == RUN);

    booth8_digit_shifter u_digit_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (run),
        .mplier (mplier_i),
        .digit  (digit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            row_src <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        row_src <= {{(ROW_W-X_W){mcand_i[X_W-1]}}, mcand_i};
                        acc     <= '0;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + row_term(row_i, digit[3], k);
                    k   <= k + 1'b1;
                    if (k == K_W'(N_DIGITS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (prod_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A zero digit outside RUN makes the generator return a zero row.
    assign digit_o       = run ? digit : 4'b0000;
    assign row_src_o     = row_src;
    assign ready_o       = (state == IDLE);
    assign prod_valid_o  = (state == DONE);
    assign prod_o        = acc[PROD_W-1:0];
    assign unused_acc_hi = ^acc[ACC_W-1:PROD_W];

endmodule

// File: tb/tb_booth8_row_accumulator.sv
// tb/tb_booth8_row_accumulator.sv - directed self-checking bench with a behavioural Booth row generator
module tb_booth8_row_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        ready_o;
    logic [12:0] mcand_i;
    logic [11:0] mplier_i;
    logic [3:0]  digit_o;
    logic [15:0] row_src_o;
    logic [15:0] row_i;
    logic [24:0] prod_o;
    logic        prod_valid_o;
    logic        prod_ready_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth8_row_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .mcand_i      (mcand_i),
        .mplier_i     (mplier_i),
        .digit_o      (digit_o),
        .row_src_o    (row_src_o),
        .row_i        (row_i),
        .prod_o       (prod_o),
        .prod_valid_o (prod_valid_o),
        .prod_ready_i (prod_ready_i)
    );

    function automatic logic [15:0] rowgen(input logic [3:0] d, input logic [15:0] x);
        int v;
        int m;
        logic [15:0] p;
        v = -4 * int'(d[3]) + 2 * int'(d[2]) + int'(d[1]) + int'(d[0]);
        m = (v < 0) ? -v : v;
        p = 16'(m * int'($signed(x)));
        return d[3] ? ~p : p;
    endfunction

    always_comb row_i = rowgen(digit_o, row_src_o);

    task automatic multiply(input logic [12:0] x, input logic [11:0] y, input logic rdy,
                            output logic [24:0] p, output int lat,
                            output logic [15:0] dgs, output logic [15:0] src);
        int b;
        b = 0;
        @(negedge clk);
        mcand_i = x; mplier_i = y; start_i = 1'b1; prod_ready_i = rdy;
        while (!ready_o && b < 20) begin @(negedge clk); b++; end
        @(negedge clk);
        start_i = 1'b0; mcand_i = ~x; mplier_i = ~y;
        lat = 1; dgs = {12'h000, digit_o}; src = row_src_o;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); lat++; dgs = {dgs[11:0], digit_o};
        end
        do begin @(negedge clk); lat++; end while (!prod_valid_o && lat < 20);
        p = prod_o;
        if (rdy) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; prod_ready_i = 1'b0; mcand_i = '0; mplier_i = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        checks++; if (prod_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", prod_valid_o); end
        checks++; if (prod_o !== 25'd0) begin errors++; $display("FAIL reset_prod got=%h want=0", prod_o); end
        checks++; if (digit_o !== 4'd0) begin errors++; $display("FAIL reset_digit got=%b want=0000", digit_o); end
        checks++; if (row_src_o !== 16'd0) begin errors++; $display("FAIL reset_row_src got=%h want=0000", row_src_o); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [24:0] p; int lat; logic [15:0] dgs, src;
        multiply(13'd3, 12'd5, 1'b1, p, lat, dgs, src);
        checks++; if (p !== 25'd15) begin errors++; $display("FAIL basic_prod got=%0d want=15", $signed(p)); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", lat); end
        checks++; if (dgs !== 16'b1010_0001_0000_0000) begin errors++; $display("FAIL basic_digits got=%h want=a100", dgs); end
        checks++; if (src !== 16'h0003) begin errors++; $display("FAIL basic_row_src got=%h want=0003", src); end
        checks++; if (prod_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL basic_handshake got valid=%b ready=%b want valid=0 ready=1", prod_valid_o, ready_o);
        end
    endtask

    task automatic test_extremes_and_zero();
        int          xs[6] = '{-4096, 4095, -4096, 0, 1234, 5};
        int          ys[6] = '{2047, -2048, -2048, -1, 0, -1};
        int          es[6] = '{-8384512, -8386560, 8388608, 0, 0, -5};
        logic [15:0] ds[6] = '{16'hEFF7, 16'h0008, 16'h0008, 16'hEFFF, 16'h0000, 16'hEFFF};
        logic [24:0] p; int lat; logic [15:0] dgs, src;
        for (int i = 0; i < 6; i++) begin
            multiply(13'(xs[i]), 12'(ys[i]), 1'b1, p, lat, dgs, src);
            checks++; if (p !== 25'(es[i])) begin
                errors++; $display("FAIL vec%0d_prod %0d*%0d got=%0d want=%0d", i, xs[i], ys[i], $signed(p), es[i]);
            end
            checks++; if (dgs !== ds[i]) begin errors++; $display("FAIL vec%0d_digits got=%h want=%h", i, dgs, ds[i]); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL vec%0d_latency got=%0d want=5", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] x; logic [11:0] y; logic [24:0] e;
        int b, lat, acc_at, prev;
        prev = 0;
        start_i = 1'b1; prod_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b = 0;
            while (!ready_o && b < 20) begin @(negedge clk); b++; end
            x = 13'($urandom); y = 12'($urandom);
            e = 25'(int'($signed(x)) * int'($signed(y)));
            mcand_i = x; mplier_i = y; acc_at = cyc;
            if (i > 0) begin
                checks++; if (acc_at - prev !== 6) begin
                    errors++; $display("FAIL b2b_spacing%0d got=%0d want=6", i, acc_at - prev);
                end
            end
            prev = acc_at;
            lat = 0;
            do begin @(negedge clk); lat++; end while (!prod_valid_o && lat < 20);
            checks++; if (prod_o !== e) begin
                errors++; $display("FAIL b2b_prod%0d %0d*%0d got=%0d want=%0d", i, $signed(x), $signed(y), $signed(prod_o), $signed(e));
            end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [24:0] p; int lat; logic [15:0] dgs, src; int bad;
        multiply(13'd100, 12'(-3), 1'b0, p, lat, dgs, src);
        checks++; if (p !== 25'(-300)) begin errors++; $display("FAIL bp_prod got=%0d want=-300", $signed(p)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_i = i[0]; mcand_i = 13'd9; mplier_i = 12'd9;
            checks++; if (prod_o !== 25'(-300) || prod_valid_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got prod=%0d valid=%b ready=%b want prod=-300 valid=1 ready=0",
                                   i, $signed(prod_o), prod_valid_o, ready_o);
            end
        end
        start_i = 1'b0; prod_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (prod_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", prod_valid_o, ready_o);
        end
        bad = 0;
        repeat (8) begin @(negedge clk); if (prod_valid_o !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_no_queue got=%0d valid cycles want=0", bad); end
    endtask

    task automatic test_reset_mid_run();
        logic [24:0] p; int lat; logic [15:0] dgs, src; int bad;
        @(negedge clk);
        mcand_i = 13'd1000; mplier_i = 12'd1000; start_i = 1'b1; prod_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready_o !== 1'b1 || prod_valid_o !== 1'b0) begin
            errors++; $display("FAIL midrst_state got ready=%b valid=%b want ready=1 valid=0", ready_o, prod_valid_o);
        end
        checks++; if (prod_o !== 25'd0 || digit_o !== 4'd0 || row_src_o !== 16'd0) begin
            errors++; $display("FAIL midrst_values got prod=%h digit=%b src=%h want 0", prod_o, digit_o, row_src_o);
        end
        bad = 0;
        repeat (6) begin @(negedge clk); if (prod_valid_o !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_glitch got=%0d valid cycles want=0", bad); end
        multiply(13'd7, 12'(-9), 1'b1, p, lat, dgs, src);
        checks++; if (p !== 25'(-63)) begin errors++; $display("FAIL midrst_prod got=%0d want=-63", $signed(p)); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency got=%0d want=5", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes_and_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
